// File: rtl/ibuf_route21_if.sv
// Link-side and allocator-side signals of one ibuf_route21 input buffer.
// master = sender/allocator side, slave = the buffer itself.
interface ibuf_route21_if #(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned WIDTH    = 3
);
  logic                in_valid;
  logic [DATASIZE-1:0] in_data;
  logic                full;
  logic                ready;
  logic [DATASIZE-1:0] data_out;
  logic [3:0]          label;
  logic [WIDTH:0]      count;
  logic [7:0]          drop_cnt;

  modport master (
    output in_valid, in_data, ready,
    input  full, data_out, label, count, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, ready,
    output full, data_out, label, count, drop_cnt
  );
endinterface

// File: rtl/ibuf_route21.sv
// Mesh router input buffer: DEPTH-entry FIFO with XY route label computed at write time.
// Optional feature: define IBUF_DROP_CNT_EN for a saturating dropped-flit counter.
module ibuf_route21 #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = 40,
  parameter logic [1:0]  LOCAL_X  = 2'd0,
  parameter logic [1:0]  LOCAL_Y  = 2'd0
) (
  input logic           clk,
  input logic           rst_n,
  ibuf_route21_if.slave bus
);

  localparam logic [WIDTH:0] DepthCnt = (WIDTH + 1)'(DEPTH);

  logic [DATASIZE+3:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH:0]      count_q;
  logic [3:0]          route_label;
  logic                route_ok;
  logic                full, empty, wr_en, rd_en;
  logic [1:0]          dst_x, dst_y;
  logic [DATASIZE+3:0] head;

  assign dst_x = bus.in_data[DATASIZE-5:DATASIZE-6];
  assign dst_y = bus.in_data[DATASIZE-7:DATASIZE-8];

  // XY routing; there is no south port on the south-edge router, so Y below us is illegal.
  always_comb begin
    route_label = 4'b0000;
    route_ok    = 1'b1;
    if (dst_x > LOCAL_X) begin
      route_label = 4'b0010;
    end else if (dst_x < LOCAL_X) begin
      route_label = 4'b0001;
    end else if (dst_y > LOCAL_Y) begin
      route_label = 4'b0100;
    end else if (dst_y == LOCAL_Y) begin
      route_label = 4'b1000;
    end else begin
      route_ok = 1'b0;
    end
  end

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign wr_en = bus.in_valid && !full && route_ok;
  assign rd_en = bus.ready && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through rd_ptr_q/count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {route_label, bus.in_data};
  end

  assign head         = mem[rd_ptr_q];
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.data_out = empty ? '0 : head[DATASIZE-1:0];
  assign bus.label    = empty ? 4'b0000 : head[DATASIZE+3:DATASIZE];

`ifdef IBUF_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q;

  assign drop = bus.in_valid && (full || !route_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'd0;
`endif

endmodule

// File: doc/ibuf_route21.md
# ibuf_route21

Input-port receive buffer with route computation for the 4-port (L, N, E, W) south-edge mesh router. It sits between a link's incoming `data_valid`/`data_out` pair, from a neighbour router or the local core, and one input of the switch allocator. It accepts flits into a DEPTH-entry FIFO and back-pressures the sender with `full`. It computes an XY-routing one-hot label at write time and presents head flit plus label, popping on the allocator's `ready`.

## Interface
- DEPTH, 8, FIFO entries
- WIDTH, 3, log2(DEPTH); pointer width
- DATASIZE, 40, flit width; [39:36] src, [35:32] dst, [31:24] timestamp, [23:2] data, [1:0] type
- LOCAL_X, 0, this router's X coordinate (2 bits)
- LOCAL_Y, 0, this router's Y coordinate (2 bits); Y grows northward, 0 = south edge
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  sender's data_valid; flit on in_data is offered this cycle
- in_data  input  DATASIZE  incoming flit
- full  output  1  back-pressure to sender; high when FIFO holds DEPTH flits
- ready  input  1  allocator grant for this input; pops head when FIFO non-empty
- data_out  output  DATASIZE  head flit to allocator (`*_data_in`)
- label  output  4  one-hot route of head flit, to allocator (`*_label`): [3]=L, [2]=N, [1]=E, [0]=W; 0 when empty
- count  output  WIDTH+1  current occupancy, 0..DEPTH
- drop_cnt  output  8  saturating count of dropped flits (see Configuration)

## Operation
- Node ID = dst[3:2] as X, dst[1:0] as Y.
- Route computation happens on the write side, combinationally from in_data:
  - dst X > LOCAL_X gives E.
  - dst X < LOCAL_X gives W.
  - Otherwise, dst Y > LOCAL_Y gives N.
  - Otherwise, dst Y == LOCAL_Y gives L.
  - dst Y < LOCAL_Y is an illegal route (no S port).
- Each stored entry holds {label, flit}, DATASIZE+4 bits.
- Write event: in_valid && !full && route legal. The entry is stored at wr_ptr and wr_ptr increments.
- Illegal route: the flit is discarded, FIFO unchanged, drop event.
- in_valid while full: the flit is discarded, FIFO unchanged, drop event. This applies even if a pop occurs the same cycle, because full is evaluated from registered count.
- Read event: ready && count != 0. rd_ptr increments and count decrements.
- ready while empty: ignored.
- Simultaneous write and read: both pointers advance and count is unchanged.
- Pointers are WIDTH bits and wrap DEPTH-1 → 0. DEPTH must be a power of two.
- data_out/label always reflect the entry at rd_ptr when count != 0. When count == 0 they are forced to 0.
- full = (count == DEPTH), decoded from the count register with no combinational path from in_valid or ready.

## Timing
- Reset (rst_n low at rising edge):
  - count, wr_ptr, rd_ptr, drop_cnt cleared to 0.
  - Outputs full=0, data_out=0, label=0, count=0, drop_cnt=0.
  - Storage contents are not cleared.
- Reset mid-operation discards all stored flits. No pop or write occurs in the reset cycle.
- Write latency: a flit accepted at edge t appears on data_out/label after edge t when the FIFO was empty. There is no same-cycle bypass.
- Pop: the head changes after the edge at which ready was sampled high. The next entry, or 0 if the FIFO is now empty, is visible in the following cycle.
- full rises the cycle after the DEPTH-th accepted write. It falls the cycle after the first pop from full.
- Sender rule: in_valid must be sampled against the registered full from the same cycle. There is a one-cycle link latency budget at most; flits beyond it are dropped.

## Configuration
- IBUF_DROP_CNT_EN:
  - Defined: drop_cnt increments by 1 on each drop event (illegal route or write-while-full) and saturates at 255.
  - Not defined: drop_cnt is tied to 0 and no counter register is synthesized. Drop behaviour itself is identical.

## Test plan
- Reset, LOCAL_X=1, LOCAL_Y=0, in_valid with dst=4'b1100 (X=3,Y=0) → after one edge, count=1, label=4'b0010 (E), data_out = flit.
- Write dst=4'b0100 (X=1,Y=0) then dst=4'b0110 (X=1,Y=2), ready=0 → head label 4'b1000 (L). After ready=1 for one cycle, head label 4'b0100 (N) and count=1.
- Write 8 flits with ready=0 → full=1 and count=8. A 9th in_valid is dropped, count stays 8, and drop_cnt=1 with the macro defined or 0 without it.
- With FIFO full, ready=1 and in_valid=1 in the same cycle → count=7, the flit is dropped, and full=0 next cycle. Stream 20 flits with ready=1 continuously → in-order delivery across pointer wrap.
- LOCAL_Y=1, write dst=4'b0000 (Y=0, southward) → flit dropped, count unchanged, label stays 0.
- Load 3 flits, assert rst_n=0 for one edge → count=0, data_out=0, label=0, full=0. A write in the next cycle is accepted normally.
